// File: rtl/pt2262_encoder_burst_pkg.sv
// Shared symbol/state types and alpha-count constants for the PT2262 burst encoder.
package pt2262_pkg;

    typedef enum logic [1:0] {SYM_0, SYM_1, SYM_F} sym_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYM_HI1,
        ST_SYM_LO1,
        ST_SYM_HI2,
        ST_SYM_LO2,
        ST_SYNC_HI,
        ST_SYNC_LO
    } state_t;

    localparam int ALPHA_SHORT   = 4;
    localparam int ALPHA_LONG    = 12;
    localparam int ALPHA_SYM     = 32;
    localparam int ALPHA_SYNC_HI = 4;
    localparam int ALPHA_SYNC_LO = 124;

    localparam int SEG_W = 7;

    // Down-counter load (length-1) for segment seg (0=hi1,1=lo1,2=hi2,3=lo2);
    // each half-symbol is 16 alpha, so the low part is whatever the high part leaves.
    function automatic logic [SEG_W-1:0] seg_load(input sym_t sym, input logic [1:0] seg);
        int hi;
        hi = (sym == SYM_1 || (sym == SYM_F && seg[1])) ? ALPHA_LONG : ALPHA_SHORT;
        return SEG_W'((seg[0] ? (ALPHA_SYM / 2 - hi) : hi) - 1);
    endfunction

endpackage

// File: rtl/pt2262_encoder_burst_alpha_tick.sv
// Alpha-period divider: one-clk tick every CLK_DIV clocks while enabled, restartable by clr.
module pt2262_alpha_tick #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = $clog2(CLK_DIV);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= CW'(CLK_DIV - 1);
        end else if (en) begin
            cnt <= (cnt == '0) ? CW'(CLK_DIV - 1) : cnt - 1'b1;
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/pt2262_encoder_burst.sv
// PT2262 pulse-width encoder with start/stop/repeat burst handshake.
// Define PT2262_ENC_FLOAT_EN to enable floating (F) address symbols via addr_float.
//
// state      | meaning
// ST_IDLE    | no burst, outputs low, waiting for start
// ST_SYM_HI1 | first high segment of current symbol
// ST_SYM_LO1 | first low segment
// ST_SYM_HI2 | second high segment
// ST_SYM_LO2 | second low segment, then next symbol or sync
// ST_SYNC_HI | 4 alpha sync high
// ST_SYNC_LO | 124 alpha sync low, then next word or end of burst
module pt2262_encoder_burst
    import pt2262_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 4,
    parameter int CLK_DIV   = 4,
    parameter int REP_W     = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 stop,
    input  logic [REP_W-1:0]     repeats,
    input  logic [ADDR_BITS-1:0] addr_val,
    input  logic [ADDR_BITS-1:0] addr_float,
    input  logic [DATA_BITS-1:0] data,
    output logic                 cod_o,
    output logic                 sync,
    output logic                 busy,
    output logic                 done
);

    localparam int NSYM  = ADDR_BITS + DATA_BITS;
    localparam int IDX_W = $clog2(NSYM + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSYM - 1);

    state_t               state;
    logic [IDX_W-1:0]     sym_idx;
    logic [SEG_W-1:0]     seg_cnt;
    logic [REP_W-1:0]     word_cnt;
    logic [REP_W-1:0]     rep_q;
    logic [ADDR_BITS-1:0] addr_val_q;
    logic [DATA_BITS-1:0] data_q;
    logic                 stop_lat;
    logic                 tick;
    logic                 accept;
    logic                 last_word;
    logic                 end_burst;
    sym_t                 cur_sym;
    sym_t                 next_sym;
    sym_t                 sym0;
    sym_t                 first_sym;

`ifdef PT2262_ENC_FLOAT_EN
    logic [ADDR_BITS-1:0] addr_float_q;
`else
    logic unused_addr_float;
    assign unused_addr_float = ^addr_float;
`endif

    function automatic sym_t sym_at(input logic [IDX_W-1:0] idx);
        logic [ADDR_BITS-1:0] a_sh;
        logic [DATA_BITS-1:0] d_sh;
`ifdef PT2262_ENC_FLOAT_EN
        logic [ADDR_BITS-1:0] f_sh;
`endif
        a_sh = addr_val_q >> idx;
        d_sh = data_q >> (idx - IDX_W'(ADDR_BITS));
        if (idx < IDX_W'(ADDR_BITS)) begin
`ifdef PT2262_ENC_FLOAT_EN
            f_sh = addr_float_q >> idx;
            if (f_sh[0]) return SYM_F;
`endif
            return a_sh[0] ? SYM_1 : SYM_0;
        end
        return d_sh[0] ? SYM_1 : SYM_0;
    endfunction

    // The first segment is loaded at accept, before the snapshot registers are valid.
    always_comb begin
        cur_sym  = sym_at(sym_idx);
        next_sym = sym_at(IDX_W'(sym_idx + 1'b1));
        sym0     = sym_at('0);
`ifdef PT2262_ENC_FLOAT_EN
        first_sym = addr_float[0] ? SYM_F : (addr_val[0] ? SYM_1 : SYM_0);
`else
        first_sym = addr_val[0] ? SYM_1 : SYM_0;
`endif
    end

    assign accept    = start && !busy;
    assign last_word = (rep_q != '0) && (REP_W'(word_cnt + 1'b1) == rep_q);
    assign end_burst = stop_lat || stop || last_word;

    pt2262_alpha_tick #(.CLK_DIV(CLK_DIV)) u_alpha_tick (
        .clk   (clk),
        .reset (reset),
        .en    (busy),
        .clr   (accept),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            sym_idx    <= '0;
            seg_cnt    <= '0;
            word_cnt   <= '0;
            rep_q      <= '0;
            addr_val_q <= '0;
            data_q     <= '0;
`ifdef PT2262_ENC_FLOAT_EN
            addr_float_q <= '0;
`endif
            stop_lat   <= 1'b0;
            cod_o      <= 1'b0;
            sync       <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            sync <= 1'b0;
            done <= 1'b0;
            if (busy && stop) stop_lat <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_SYM_HI1;
                        busy       <= 1'b1;
                        cod_o      <= 1'b1;
                        sym_idx    <= '0;
                        word_cnt   <= '0;
                        stop_lat   <= 1'b0;
                        seg_cnt    <= seg_load(first_sym, 2'd0);
                        addr_val_q <= addr_val;
                        data_q     <= data;
                        rep_q      <= repeats;
`ifdef PT2262_ENC_FLOAT_EN
                        addr_float_q <= addr_float;
`endif
                    end
                end
                default: begin
                    if (tick) begin
                        if (seg_cnt != '0) begin
                            seg_cnt <= seg_cnt - 1'b1;
                        end else begin
                            case (state)
                                ST_SYM_HI1: begin
                                    state   <= ST_SYM_LO1;
                                    cod_o   <= 1'b0;
                                    seg_cnt <= seg_load(cur_sym, 2'd1);
                                end
                                ST_SYM_LO1: begin
                                    state   <= ST_SYM_HI2;
                                    cod_o   <= 1'b1;
                                    seg_cnt <= seg_load(cur_sym, 2'd2);
                                end
                                ST_SYM_HI2: begin
                                    state   <= ST_SYM_LO2;
                                    cod_o   <= 1'b0;
                                    seg_cnt <= seg_load(cur_sym, 2'd3);
                                end
                                ST_SYM_LO2: begin
                                    cod_o <= 1'b1;
                                    if (sym_idx == LAST_IDX) begin
                                        state   <= ST_SYNC_HI;
                                        sync    <= 1'b1;
                                        seg_cnt <= SEG_W'(ALPHA_SYNC_HI - 1);
                                    end else begin
                                        state   <= ST_SYM_HI1;
                                        sym_idx <= sym_idx + 1'b1;
                                        seg_cnt <= seg_load(next_sym, 2'd0);
                                    end
                                end
                                ST_SYNC_HI: begin
                                    state   <= ST_SYNC_LO;
                                    cod_o   <= 1'b0;
                                    seg_cnt <= SEG_W'(ALPHA_SYNC_LO - 1);
                                end
                                ST_SYNC_LO: begin
                                    word_cnt <= word_cnt + 1'b1;
                                    sym_idx  <= '0;
                                    if (end_burst) begin
                                        state    <= ST_IDLE;
                                        busy     <= 1'b0;
                                        done     <= 1'b1;
                                        cod_o    <= 1'b0;
                                        stop_lat <= 1'b0;
                                    end else begin
                                        state   <= ST_SYM_HI1;
                                        cod_o   <= 1'b1;
                                        seg_cnt <= seg_load(sym0, 2'd0);
                                    end
                                end
                                default: state <= ST_IDLE;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule
